// File: rtl/stream_sort_engine.sv
// Stream sort engine: reads up to DEPTH elements, sorts them with an odd-even transposition network, writes them back.
// Optional macro SORT_DIR_SEL_EN adds a descend input selecting descending order with zero padding.
`timescale 1ns/1ps
module stream_sort_engine #(
    parameter int DSIZE  = 64,
    parameter int DEPTH  = 32,
    parameter int AWIDTH = 64
) (
    input  logic              clk,
    input  logic              reset,
`ifdef SORT_DIR_SEL_EN
    input  logic              descend,
`endif
    input  logic              start,
    input  logic [AWIDTH-1:0] read_base,
    input  logic [AWIDTH-1:0] write_base,
    input  logic [AWIDTH-1:0] num_read,
    input  logic [AWIDTH-1:0] elem_size,
    input  logic              read_ready,
    input  logic [DSIZE-1:0]  read_data,
    input  logic              write_ready,
    output logic              read_enable,
    output logic              write_enable,
    output logic              finish_read,
    output logic              finish_write,
    output logic [AWIDTH-1:0] read_addr,
    output logic [AWIDTH-1:0] write_addr,
    output logic [AWIDTH-1:0] read_size_output,
    output logic [AWIDTH-1:0] write_size,
    output logic [DSIZE-1:0]  write_data,
    output logic              busy,
    output logic              done,
    output logic              err
);
    localparam int CW = $clog2(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE, S_WAIT_READ, S_DEAL_READ, S_SORT, S_WAIT_WRITE, S_DEAL_WRITE, S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [AWIDTH-1:0] read_addr_q, read_addr_d, write_addr_q, write_addr_d;
    logic [AWIDTH-1:0] num_q, num_d, size_q, size_d, wbase_q, wbase_d;
    logic [CW-1:0]     read_cnt_q, read_cnt_d, write_cnt_q, write_cnt_d, sort_cnt_q, sort_cnt_d;
    logic              read_enable_q, read_enable_d, write_enable_q, write_enable_d;
    logic              finish_read_q, finish_read_d, finish_write_q, finish_write_d;
    logic              done_q, done_d, err_q, err_d, desc_q, desc_d;
    logic [DSIZE-1:0]  write_data_q, write_data_d;
    logic [DSIZE-1:0]  mem_q [DEPTH];
    logic [DSIZE-1:0]  mem_d [DEPTH];
    logic              desc_in;

`ifdef SORT_DIR_SEL_EN
    assign desc_in = descend;
`else
    assign desc_in = 1'b0;
`endif

    always_comb begin
        // NOTE: every _d gets its current value first so no path through this block can infer a latch.
        state_d        = state_q;
        read_addr_d    = read_addr_q;
        write_addr_d   = write_addr_q;
        num_d          = num_q;
        size_d         = size_q;
        wbase_d        = wbase_q;
        read_cnt_d     = read_cnt_q;
        write_cnt_d    = write_cnt_q;
        sort_cnt_d     = sort_cnt_q;
        read_enable_d  = read_enable_q;
        write_enable_d = write_enable_q;
        finish_read_d  = finish_read_q;
        finish_write_d = finish_write_q;
        done_d         = done_q;
        err_d          = err_q;
        desc_d         = desc_q;
        write_data_d   = write_data_q;
        mem_d          = mem_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    num_d       = num_read;
                    size_d      = elem_size;
                    wbase_d     = write_base;
                    desc_d      = desc_in;
                    done_d      = 1'b0;
                    err_d       = 1'b0;
                    read_cnt_d  = '0;
                    write_cnt_d = '0;
                    // Pre-fill with padding so unused slots sink to the tail during the sort.
                    for (int i = 0; i < DEPTH; i++) mem_d[i] = desc_in ? '0 : '1;
                    if (num_read == '0) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else if (num_read > AWIDTH'(DEPTH)) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                        err_d   = 1'b1;
                    end else begin
                        read_addr_d   = read_base;
                        read_enable_d = 1'b1;
                        state_d       = S_WAIT_READ;
                    end
                end
            end
            S_WAIT_READ: begin
                finish_read_d = 1'b0;
                if (read_ready) begin
                    mem_d[read_cnt_q] = read_data;
                    state_d           = S_DEAL_READ;
                end
            end
            S_DEAL_READ: begin
                if (AWIDTH'(read_cnt_q) == num_q - 1'b1) begin
                    read_enable_d = 1'b0;
                    sort_cnt_d    = '0;
                    state_d       = S_SORT;
                end else begin
                    read_cnt_d    = read_cnt_q + 1'b1;
                    read_addr_d   = read_addr_q + size_q;
                    finish_read_d = 1'b1;
                    state_d       = S_WAIT_READ;
                end
            end
            S_SORT: begin
                // Even phase pairs (0,1),(2,3)..; odd phase pairs (1,2),(3,4)..; strict compare keeps equal keys in order.
                for (int i = 0; i < DEPTH - 1; i++) begin
                    if (i[0] == sort_cnt_q[0]) begin
                        if (desc_q ? (mem_q[i] < mem_q[i+1]) : (mem_q[i] > mem_q[i+1])) begin
                            mem_d[i]   = mem_q[i+1];
                            mem_d[i+1] = mem_q[i];
                        end
                    end
                end
                if (sort_cnt_q == CW'(DEPTH - 1)) begin
                    write_addr_d   = wbase_q;
                    write_data_d   = mem_d[0];
                    write_enable_d = 1'b1;
                    state_d        = S_WAIT_WRITE;
                end else begin
                    sort_cnt_d = sort_cnt_q + 1'b1;
                end
            end
            S_WAIT_WRITE: begin
                finish_write_d = 1'b0;
                if (write_ready) state_d = S_DEAL_WRITE;
            end
            S_DEAL_WRITE: begin
                if (AWIDTH'(write_cnt_q) == num_q - 1'b1) begin
                    write_enable_d = 1'b0;
                    done_d         = 1'b1;
                    state_d        = S_DONE;
                end else begin
                    write_cnt_d    = write_cnt_q + 1'b1;
                    write_data_d   = mem_q[write_cnt_q + 1'b1];
                    write_addr_d   = write_addr_q + size_q;
                    finish_write_d = 1'b1;
                    state_d        = S_WAIT_WRITE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= S_IDLE;
            read_addr_q    <= '0;
            write_addr_q   <= '0;
            num_q          <= '0;
            size_q         <= '0;
            wbase_q        <= '0;
            read_cnt_q     <= '0;
            write_cnt_q    <= '0;
            sort_cnt_q     <= '0;
            read_enable_q  <= 1'b0;
            write_enable_q <= 1'b0;
            finish_read_q  <= 1'b0;
            finish_write_q <= 1'b0;
            done_q         <= 1'b0;
            err_q          <= 1'b0;
            desc_q         <= 1'b0;
            write_data_q   <= '0;
        end else begin
            state_q        <= state_d;
            read_addr_q    <= read_addr_d;
            write_addr_q   <= write_addr_d;
            num_q          <= num_d;
            size_q         <= size_d;
            wbase_q        <= wbase_d;
            read_cnt_q     <= read_cnt_d;
            write_cnt_q    <= write_cnt_d;
            sort_cnt_q     <= sort_cnt_d;
            read_enable_q  <= read_enable_d;
            write_enable_q <= write_enable_d;
            finish_read_q  <= finish_read_d;
            finish_write_q <= finish_write_d;
            done_q         <= done_d;
            err_q          <= err_d;
            desc_q         <= desc_d;
            write_data_q   <= write_data_d;
        end
    end

    // NOTE: element storage has no reset; every job pads and reloads it before use, so a reset would only add fan-out.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign read_enable      = read_enable_q;
    assign write_enable     = write_enable_q;
    assign finish_read      = finish_read_q;
    assign finish_write     = finish_write_q;
    assign read_addr        = read_addr_q;
    assign write_addr       = write_addr_q;
    assign read_size_output = size_q;
    assign write_size       = size_q;
    assign write_data       = write_data_q;
    assign busy             = (state_q != S_IDLE) && (state_q != S_DONE);
    assign done             = done_q;
    assign err              = err_q;
endmodule

// File: tb/tb_stream_sort_engine.sv
// Directed bench for stream_sort_engine: the bench acts as the memory, checks addresses, ordering and control pulses.
`timescale 1ns/1ps
module tb_stream_sort_engine;
    localparam int DSIZE  = 64;
    localparam int DEPTH  = 32;
    localparam int AWIDTH = 64;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              start = 1'b0;
    logic              descend = 1'b0;
    logic [AWIDTH-1:0] read_base = '0, write_base = '0, num_read = '0, elem_size = '0;
    logic              read_ready = 1'b0, write_ready = 1'b0;
    logic [DSIZE-1:0]  read_data = '0;
    logic              read_enable, write_enable, finish_read, finish_write, busy, done, err;
    logic [AWIDTH-1:0] read_addr, write_addr, read_size_output, write_size;
    logic [DSIZE-1:0]  write_data;

    int checks = 0;
    int failures = 0;
    int sort_cycles;
    logic [DSIZE-1:0]  src      [DEPTH];
    logic [DSIZE-1:0]  got_data [DEPTH];
    logic [AWIDTH-1:0] got_addr [DEPTH];

    always #5 clk = ~clk;

    stream_sort_engine #(.DSIZE(DSIZE), .DEPTH(DEPTH), .AWIDTH(AWIDTH)) dut (
        .clk(clk), .reset(reset),
`ifdef SORT_DIR_SEL_EN
        .descend(descend),
`endif
        .start(start), .read_base(read_base), .write_base(write_base),
        .num_read(num_read), .elem_size(elem_size), .read_ready(read_ready),
        .read_data(read_data), .write_ready(write_ready), .read_enable(read_enable),
        .write_enable(write_enable), .finish_read(finish_read), .finish_write(finish_write),
        .read_addr(read_addr), .write_addr(write_addr), .read_size_output(read_size_output),
        .write_size(write_size), .write_data(write_data), .busy(busy), .done(done), .err(err)
    );

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    // Runs one job with the bench acting as memory; abort_at >= 0 stops before that read beat.
    task automatic run_job(input int n, input logic [AWIDTH-1:0] rbase, input logic [AWIDTH-1:0] wbase,
                           input logic [AWIDTH-1:0] esize, input int abort_at, input bit poke);
        @(negedge clk);
        start = 1'b1; read_base = rbase; write_base = wbase; num_read = AWIDTH'(n); elem_size = esize;
        @(negedge clk);
        start = 1'b0; read_base = 64'hDEAD_0000; write_base = 64'hBEEF_0000; num_read = 7; elem_size = 3;
        sort_cycles = 0;
        for (int k = 0; k < n; k++) begin
            if (k == abort_at) return;
            checks++;
            if (read_enable !== 1'b1 || read_addr !== rbase + esize * AWIDTH'(k)) begin
                failures++;
                $display("FAIL read_beat%0d: en=%b addr=%h required en=1 addr=%h", k, read_enable, read_addr, rbase + esize * AWIDTH'(k));
                return;
            end
            read_data = src[k];
            read_ready = 1'b1;
            if (poke && k == 1) begin
                start = 1'b1; num_read = 1;
            end
            @(negedge clk);
            read_ready = 1'b0; start = 1'b0; read_data = '0;
            @(negedge clk);
            if (k < n - 1) begin
                checks++;
                if (finish_read !== 1'b1) begin
                    failures++;
                    $display("FAIL finish_read%0d: got %b required 1", k, finish_read);
                end
            end
        end
        while (write_enable !== 1'b1 && sort_cycles < 100) begin
            sort_cycles++;
            @(negedge clk);
        end
        checks++;
        if (sort_cycles !== DEPTH) begin
            failures++;
            $display("FAIL sort_cycles: got %0d required %0d", sort_cycles, DEPTH);
        end
        for (int k = 0; k < n; k++) begin
            if (write_enable !== 1'b1) begin
                checks++; failures++;
                $display("FAIL write_beat%0d: write_enable got %b required 1", k, write_enable);
                return;
            end
            got_addr[k] = write_addr;
            got_data[k] = write_data;
            write_ready = 1'b1;
            @(negedge clk);
            write_ready = 1'b0;
            @(negedge clk);
            checks++;
            if (k < n - 1) begin
                if (finish_write !== 1'b1) begin
                    failures++;
                    $display("FAIL finish_write%0d: got %b required 1", k, finish_write);
                end
            end else if ({done, write_enable, busy, err} !== 4'b1000) begin
                failures++;
                $display("FAIL job_end: done/we/busy/err got %b required 1000", {done, write_enable, busy, err});
            end
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({read_enable, write_enable, finish_read, finish_write, read_addr, write_addr,
             read_size_output, write_size, write_data, busy, done, err} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: some output nonzero (busy=%b done=%b ra=%h) required all 0", busy, done, read_addr);
        end
        reset = 1'b0;
    endtask

    task automatic test_basic;
        logic [DSIZE-1:0] exp_d [5];
        exp_d = '{1, 3, 3, 7, 9};
        src[0] = 9; src[1] = 3; src[2] = 7; src[3] = 3; src[4] = 1;
        run_job(5, 64'h100, 64'h1000, 8, -1, 1'b1);
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (got_data[k] !== exp_d[k] || got_addr[k] !== 64'h1000 + 64'(8 * k)) begin
                failures++;
                $display("FAIL basic_out%0d: data=%0d addr=%h required data=%0d addr=%h", k, got_data[k], got_addr[k], exp_d[k], 64'h1000 + 64'(8 * k));
            end
        end
        checks++;
        if (write_size !== 64'd8 || read_size_output !== 64'd8) begin
            failures++;
            $display("FAIL basic_size: write_size=%0d read_size=%0d required 8", write_size, read_size_output);
        end
    endtask

    task automatic test_reverse;
        for (int k = 0; k < DEPTH; k++) src[k] = DSIZE'(DEPTH - k);
        run_job(DEPTH, 64'h0, 64'h4000, 4, -1, 1'b0);
        for (int k = 0; k < DEPTH; k++) begin
            checks++;
            if (got_data[k] !== DSIZE'(k + 1) || got_addr[k] !== 64'h4000 + 64'(4 * k)) begin
                failures++;
                $display("FAIL reverse_out%0d: data=%0d addr=%h required data=%0d addr=%h", k, got_data[k], got_addr[k], k + 1, 64'h4000 + 64'(4 * k));
            end
        end
    endtask

    task automatic test_reject(input int n, input logic exp_err);
        bit saw_enable;
        saw_enable = 1'b0;
        @(negedge clk);
        start = 1'b1; num_read = AWIDTH'(n); read_base = 64'h200; write_base = 64'h300; elem_size = 8;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < 4; c++) begin
            if (read_enable || write_enable) saw_enable = 1'b1;
            if (c == 1) begin
                checks++;
                if ({done, err, busy} !== {1'b1, exp_err, 1'b0}) begin
                    failures++;
                    $display("FAIL reject_n%0d: done/err/busy got %b required %b", n, {done, err, busy}, {1'b1, exp_err, 1'b0});
                end
            end
            @(negedge clk);
        end
        checks++;
        if (saw_enable) begin
            failures++;
            $display("FAIL reject_n%0d_enables: read/write enable got 1 required 0", n);
        end
    endtask

    task automatic test_reset_mid;
        for (int k = 0; k < 10; k++) src[k] = DSIZE'(100 + k);
        run_job(10, 64'h800, 64'h900, 8, 3, 1'b0);
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({read_enable, write_enable, finish_read, finish_write, read_addr, write_addr,
             read_size_output, write_size, write_data, busy, done, err} !== '0) begin
            failures++;
            $display("FAIL reset_mid_outputs: busy=%b re=%b ra=%h required all 0", busy, read_enable, read_addr);
        end
        @(negedge clk);
        reset = 1'b0;
        src[0] = 4; src[1] = 2; src[2] = 8;
        run_job(3, 64'h10, 64'h20, 16, -1, 1'b0);
        checks++;
        if (got_data[0] !== 2 || got_data[1] !== 4 || got_data[2] !== 8 || got_addr[2] !== 64'h40) begin
            failures++;
            $display("FAIL reset_mid_rerun: data=%0d,%0d,%0d addr2=%h required 2,4,8 addr2=40", got_data[0], got_data[1], got_data[2], got_addr[2]);
        end
    endtask

    task automatic test_wrap;
        logic [AWIDTH-1:0] exp_a [3];
        exp_a = '{64'hFFFF_FFFF_FFFF_FFF8, 64'h0, 64'h8};
        src[0] = 5; src[1] = 4; src[2] = 6;
        run_job(3, 64'hFFFF_FFFF_FFFF_FFF0, 64'hFFFF_FFFF_FFFF_FFF8, 8, -1, 1'b0);
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (got_addr[k] !== exp_a[k] || got_data[k] !== DSIZE'(k + 4)) begin
                failures++;
                $display("FAIL wrap_out%0d: addr=%h data=%0d required addr=%h data=%0d", k, got_addr[k], got_data[k], exp_a[k], k + 4);
            end
        end
    endtask

`ifdef SORT_DIR_SEL_EN
    task automatic test_descend;
        descend = 1'b1;
        src[0] = 2; src[1] = 5; src[2] = 1;
        run_job(3, 64'h0, 64'h500, 8, -1, 1'b1);
        descend = 1'b0;
        checks++;
        if (got_data[0] !== 5 || got_data[1] !== 2 || got_data[2] !== 1) begin
            failures++;
            $display("FAIL descend_out: got %0d,%0d,%0d required 5,2,1", got_data[0], got_data[1], got_data[2]);
        end
    endtask
`endif

    initial begin
        test_reset;
        test_basic;
        test_reverse;
        test_reject(33, 1'b1);
        test_reject(0, 1'b0);
        test_reset_mid;
        test_wrap;
`ifdef SORT_DIR_SEL_EN
        test_descend;
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/stream_sort_engine.md
STREAM_SORT_ENGINE -- requirements
Module: stream_sort_engine

Interface
REQ-001 Parameter DSIZE, 64, element and data-bus width in bits.
REQ-002 Parameter DEPTH, 32, maximum elements per job (power of two, 2..256).
REQ-003 Parameter AWIDTH, 64, address and size width in bits.
REQ-004 clk  in  1  sole clock; all state changes on its rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 start  in  1  one-cycle job request; sampled only in IDLE or DONE.
REQ-007 read_base, write_base  in  AWIDTH  first source and destination addresses.
REQ-008 num_read  in  AWIDTH  element count; sampled on the accepted start.
REQ-009 elem_size  in  AWIDTH  address stride; sampled on the accepted start.
REQ-010 read_ready  in  1  memory has valid read_data for the current read_addr.
REQ-011 read_data  in  DSIZE  returned element.
REQ-012 write_ready  in  1  memory has accepted write_data at write_addr.
REQ-013 read_enable, write_enable  out  1  read or write phase active.
REQ-014 finish_read, finish_write  out  1  one-cycle pulse: beat consumed, next beat is presented.
REQ-015 read_addr, write_addr  out  AWIDTH  current beat address.
REQ-016 read_size_output, write_size  out  AWIDTH  copy of the sampled elem_size.
REQ-017 write_data  out  DSIZE  current output element.
REQ-018 busy  out  1  high in every state except IDLE and DONE.
REQ-019 done  out  1  high in DONE; err  out  1  job rejected.

Function
REQ-020 States: IDLE, WAIT_READ, DEAL_READ, SORT, WAIT_WRITE, DEAL_WRITE, DONE.
REQ-021 IDLE/DONE + start: latch parameters; clear done and err; set read_addr to read_base; set read_enable to 1; go to WAIT_READ.
REQ-022 On an accepted start, num_read = 0 goes directly to DONE with err = 0 and no transfers.
REQ-023 On an accepted start, num_read > DEPTH goes directly to DONE with err = 1 and no transfers.
REQ-024 WAIT_READ: finish_read = 0; when read_ready = 1, store read_data in slot read_cnt and go to DEAL_READ.
REQ-025 DEAL_READ with more elements remaining: read_cnt+1; read_addr += elem_size; finish_read = 1 for one cycle; return to WAIT_READ.
REQ-026 DEAL_READ on the last element: read_enable = 0; go to SORT.
REQ-027 SORT: on SORT entry, slots at index >= num_read hold the padding value; padding is all-ones (ascending) or zero (descending).
REQ-028 SORT: odd-even transposition sort, unsigned compare, one phase per cycle (even pairs, then odd pairs), exactly DEPTH cycles; then go to WAIT_WRITE.
REQ-029 On SORT exit: write_addr = write_base; write_data = slot 0; write_enable = 1.
REQ-030 WAIT_WRITE: finish_write = 0; write_ready = 1 goes to DEAL_WRITE.
REQ-031 DEAL_WRITE with more elements remaining: write_cnt+1; write_data = next slot; write_addr += elem_size; finish_write = 1 for one cycle; return to WAIT_WRITE.
REQ-032 DEAL_WRITE on the last element: write_enable = 0; done = 1; go to DONE.
REQ-033 Address arithmetic is modulo 2^AWIDTH; wrap-around is permitted and is not an error.
REQ-034 start while busy = 1 is ignored.
REQ-035 read_ready is ignored outside WAIT_READ; write_ready is ignored outside WAIT_WRITE.
REQ-036 Equal keys keep a stable output order; the output multiset equals the input multiset.

Reset
REQ-037 Reset asserted at any time, including mid-job, immediately forces IDLE.
REQ-038 During and after reset, all outputs are 0 and read_cnt and write_cnt are 0.
REQ-039 Element slots are not reset; they are undefined until loaded.
REQ-040 The first start is accepted on the first rising clk after reset deasserts.

Configuration
REQ-041 Macro SORT_DIR_SEL_EN.
REQ-042 When SORT_DIR_SEL_EN is defined: add input port descend (1 bit); it is sampled on the accepted start; 1 = descending sort with zero padding.
REQ-043 When SORT_DIR_SEL_EN is undefined: the descend port is absent and the sort is always ascending with all-ones padding.

Verification
REQ-044 DEPTH=32; num_read=5; data {9,3,7,3,1}; read_ready every 2nd cycle -> written data 1,3,3,7,9 at write_base + 0,8,16,24,32 (elem_size=8); done=1.
REQ-045 num_read=32 with a reverse-ordered input -> ascending output; sort phase lasts exactly 32 cycles; done asserts after the 32nd write.
REQ-046 num_read=0 -> done=1 two cycles after start; read_enable and write_enable never assert. num_read=33 -> done=1 and err=1.
REQ-047 reset asserted at read beat 3 of 10 -> all outputs 0 in the same cycle; a new job after reset completes correctly.
REQ-048 write_base=2^64-8, elem_size=8, num_read=3 -> write_addr sequence 2^64-8, 0, 8.
REQ-049 With SORT_DIR_SEL_EN defined: descend=1, data {2,5,1} -> output 5,2,1; start pulsed while busy has no effect.
